// File: rtl/mcycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit:
// state/class encodings, opcode/funct values and ALU op codes.
package mcycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_RALU = 4'd0,
    C_IALU = 4'd1,
    C_LW   = 4'd2,
    C_SW   = 4'd3,
    C_J    = 4'd4,
    C_JAL  = 4'd5,
    C_JR   = 4'd6,
    C_BEQ  = 4'd7,
    C_BAD  = 4'd8
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [5:0] ALU_NOP  = 6'h00;
  localparam logic [5:0] ALU_LUI  = 6'h0F;
  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_ADDU = 6'h21;
  localparam logic [5:0] ALU_SUBU = 6'h23;
  localparam logic [5:0] ALU_AND  = 6'h24;
  localparam logic [5:0] ALU_OR   = 6'h25;
  localparam logic [5:0] ALU_SLT  = 6'h2A;

  typedef struct packed {
    cls_e       cls;
    logic [5:0] alu;
    logic       s_ext;
    logic       s_b;
  } dec_t;

  // Classes that finish in EXEC (control transfers).
  function automatic logic ends_in_exec(cls_e c);
    return (c == C_J) || (c == C_JAL) ||
           (c == C_JR) || (c == C_BEQ);
  endfunction

endpackage

// File: rtl/mcycle_ctrl_if.sv
// Instruction/data memory handshake bundle.
// master = control unit, slave = memory side.
interface mcycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic mem_write;

  modport master (
    output imem_req,
    output dmem_req,
    output mem_write,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  mem_write,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/mcycle_ctrl_decode.sv
// Combinational instruction classifier.
// Yields the class plus the EXEC-phase ALU/operand selects.
module mc_decode
  import mcycle_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  // Map opcode/funct onto class and EXEC selects.
  always_comb begin
    dec_o = '{cls: C_BAD, alu: ALU_NOP,
              s_ext: 1'b0, s_b: 1'b0};
    unique case (op_i)
      OP_RTYPE: begin
        dec_o.cls = C_RALU;
        unique case (funct_i)
          FN_ADDU: dec_o.alu = ALU_ADDU;
          FN_SUBU: dec_o.alu = ALU_SUBU;
          FN_ADD:  dec_o.alu = ALU_ADD;
          FN_AND:  dec_o.alu = ALU_AND;
          FN_OR:   dec_o.alu = ALU_OR;
          FN_SLT:  dec_o.alu = ALU_SLT;
          FN_JR:   dec_o.cls = C_JR;
          default: dec_o.cls = C_BAD;
        endcase
      end
      OP_ADDI: dec_o = '{C_IALU, ALU_ADD, 1'b1, 1'b1};
      OP_ADDIU: dec_o = '{C_IALU, ALU_ADDU, 1'b1, 1'b1};
      OP_ANDI: dec_o = '{C_IALU, ALU_AND, 1'b0, 1'b1};
      OP_ORI:  dec_o = '{C_IALU, ALU_OR, 1'b0, 1'b1};
      OP_LUI:  dec_o = '{C_IALU, ALU_LUI, 1'b0, 1'b1};
      OP_LW:   dec_o = '{C_LW, ALU_ADDU, 1'b1, 1'b1};
      OP_SW:   dec_o = '{C_SW, ALU_ADDU, 1'b1, 1'b1};
      OP_J:    dec_o.cls = C_J;
      OP_JAL:  dec_o.cls = C_JAL;
      OP_BEQ:  dec_o = '{C_BEQ, ALU_SUBU, 1'b1, 1'b0};
      default: dec_o.cls = C_BAD;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory wait timeout.
// Outputs are decoded combinationally from the current state.
module mcycle_ctrl
  import mcycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        zero,
  mcycle_ctrl_if.master mem,
  output logic        pc_write,
  output logic        ir_write,
  output logic [5:0]  alu_ctrl,
  output logic        s_ext,
  output logic        s_b,
  output logic        reg_write,
  output logic [1:0]  s_num_write,
  output logic [1:0]  s_data_write,
  output logic [1:0]  s_npc,
  output logic        retire,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST =
    CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  dec_t          dec_q, dec_d, dec_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic          unused_bits;

  assign unused_bits = ^instruction[25:6];

  mc_decode u_dec (
    .op_i    (instruction[31:26]),
    .funct_i (instruction[5:0]),
    .dec_o   (dec_w)
  );

  // Next state, wait counter and sticky fault.
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    cnt_d   = '0;
    fault_d = fault_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem.imem_ready) begin
          state_d = S_DECODE;
        end else if (cnt_q == LAST) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        dec_d = dec_w;
        if (dec_w.cls == C_BAD) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (dec_q.cls)
          C_RALU, C_IALU: state_d = S_WB;
          C_LW, C_SW:     state_d = S_MEM;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem.dmem_ready) begin
          state_d = (dec_q.cls == C_SW) ?
                    S_FETCH : S_WB;
        end else if (cnt_q == LAST) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    endcase
  end

  // State, decoded class, counter and fault registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      dec_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    mem.imem_req  = 1'b0;
    mem.dmem_req  = 1'b0;
    mem.mem_write = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    alu_ctrl      = ALU_NOP;
    s_ext         = 1'b0;
    s_b           = 1'b0;
    reg_write     = 1'b0;
    s_num_write   = 2'b00;
    s_data_write  = 2'b00;
    s_npc         = 2'b00;
    retire        = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        alu_ctrl = dec_q.alu;
        s_ext    = dec_q.s_ext;
        s_b      = dec_q.s_b;
        retire   = ends_in_exec(dec_q.cls);
        unique case (dec_q.cls)
          C_J: begin
            pc_write = 1'b1;
            s_npc    = 2'b01;
          end
          C_JR: begin
            pc_write = 1'b1;
            s_npc    = 2'b10;
          end
          C_JAL: begin
            pc_write     = 1'b1;
            s_npc        = 2'b01;
            reg_write    = 1'b1;
            s_num_write  = 2'b10;
            s_data_write = 2'b10;
          end
          C_BEQ: begin
            pc_write = zero;
            s_npc    = 2'b11;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem.dmem_req  = 1'b1;
        mem.mem_write = (dec_q.cls == C_SW);
        retire = mem.dmem_ready &&
                 (dec_q.cls == C_SW);
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        if (dec_q.cls == C_RALU)
          s_num_write = 2'b01;
        if (dec_q.cls == C_LW)
          s_data_write = 2'b01;
      end
      default: ;
    endcase
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, max wait cycles for imem_ready/dmem_ready before fault.
REQ-002 Reset: one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-003 Ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-004 Ports: instruction  in  32  IR contents, stable from DECODE onward; zero  in  1  ALU equality flag.
REQ-005 Ports: imem_ready  in  1  fetch data valid; dmem_ready  in  1  data access complete.
REQ-006 Ports: imem_req, dmem_req  out  1  memory requests; pc_write, ir_write  out  1  PC/IR load enables.
REQ-007 Ports: alu_ctrl  out  6  ALU op code; s_ext, s_b, mem_write, reg_write  out  1  datapath selects/enables.
REQ-008 Ports: s_num_write, s_data_write, s_npc  out  2  dest-reg, writeback and next-PC selects.
REQ-009 Ports: retire  out  1  one-cycle pulse per completed instruction; fault  out  1  sticky error; state  out  3  current state.

Function
REQ-010 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-011 FETCH: imem_req=1 until imem_ready; the ready cycle asserts ir_write=1, pc_write=1, s_npc=00; next DECODE.
REQ-012 DECODE SHALL last exactly one cycle and register the instruction class from instruction[31:26] and [5:0].
REQ-013 Supported: R-type addu, subu, add, and, or, slt, jr; addi, addiu, andi, ori, lui, lw, sw, j, jal, beq; standard MIPS encodings.
REQ-014 Any other opcode or R-type funct SHALL go DECODE->HALT, set fault, no pc_write/reg_write/mem_write.
REQ-015 EXEC SHALL drive alu_ctrl, s_b, s_ext for the class (R-type s_b=0 s_ext=0; addi/addiu/lw/sw/beq s_ext=1; andi/ori/lui s_ext=0).
REQ-016 R-type ALU and I-type ALU: EXEC->WB; WB asserts reg_write=1, s_data_write=00, s_num_write=01 (R) / 00 (I).
REQ-017 lw: EXEC->MEM (dmem_req=1 until dmem_ready)->WB with s_data_write=01, s_num_write=00.
REQ-018 sw: EXEC->MEM with dmem_req=1, mem_write=1 until dmem_ready; then FETCH, no WB.
REQ-019 j: EXEC asserts pc_write=1, s_npc=01; jr: pc_write=1, s_npc=10; both ->FETCH.
REQ-020 jal: EXEC asserts pc_write=1, s_npc=01, reg_write=1, s_num_write=10, s_data_write=10; ->FETCH.
REQ-021 beq: EXEC asserts pc_write=zero, s_npc=11, s_b=0; ->FETCH.
REQ-022 retire SHALL pulse on the last cycle of each instruction (WB, sw MEM ready cycle, or jump/branch EXEC).
REQ-023 Wait counter SHALL count cycles in FETCH/MEM with ready low; at MEM_TIMEOUT consecutive waits -> HALT, fault=1.
REQ-024 Counter SHALL clear on every state transition; ready arriving on the MEM_TIMEOUT-th cycle is accepted (no fault).
REQ-025 Write enables (pc_write, ir_write, reg_write, mem_write) SHALL be 0 in every state/case not listed; selects default 00.
REQ-026 HALT SHALL be absorbing: all enables and requests 0 until rst.
REQ-027 Instruction latency: ALU 4 cycles, lw 5, sw 4, j/jal/jr/beq 3, with zero-wait memory.

Reset
REQ-028 rst SHALL asynchronously force state=FETCH, fault=0, counter=0, retire=0; outputs combinational from state.
REQ-029 rst asserted mid-MEM SHALL drop dmem_req and mem_write in the same cycle; no pending write completes.

Structure
REQ-030 ALU op codes, opcode/funct values and state encodings SHALL live in the shared include package; ctrl decoders use the same ALU codes.
REQ-031 Sub-module mc_decode (combinational instruction class + EXEC selects) SHALL be instantiated once; FSM and counter in mcycle_ctrl.

Verification
REQ-032 addu $3,$1,$2 (0x00221821), zero-wait: FETCH,DECODE,EXEC,WB; reg_write=1, s_num_write=01 in cycle 4; retire cycle 4.
REQ-033 lw (0x8C220004), dmem_ready after 3 waits: MEM held 4 cycles, dmem_req=1, mem_write=0, then WB s_data_write=01.
REQ-034 beq (0x10220003) with zero=1 then zero=0: pc_write=1 vs 0 in EXEC, s_npc=11 both.
REQ-035 Opcode 0x3F: HALT after DECODE, fault=1, no enables thereafter; imem_ready held 0 for 16 cycles also -> fault.
REQ-036 jal (0x0C000010): EXEC pc_write=1, reg_write=1, s_num_write=10, s_data_write=10; rst during sw MEM -> FETCH, mem_write=0 immediately.
